// File: rtl/qu_common_pkg.sv
// Shared reservation-station definitions.
// Package qu_common: default depth and tag width for res_st_ctrl, and the
// per-entry control-state type res_st_ctrl_t.
package qu_common;

    localparam int QU_RES_ST_DEPTH = 32;
    localparam int QU_TAG_W        = 6;

    // Control bits kept per entry; the producer tags live beside it in
    // arrays sized by the instance's TAG_W.
    typedef struct packed {
        logic valid;
        logic rdy1;
        logic rdy2;
    } res_st_ctrl_t;

endpackage

// File: rtl/res_st_ctrl_prio_enc.sv
// prio_enc: lowest-index priority search.
// Ports:
//   req   - request vector, bit i set means candidate i
//   found - any request set
//   idx   - index of the lowest set bit (0 when none)
module prio_enc #(
    parameter  int N  = 32,
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          found,
    output logic [AW-1:0] idx
);

    always_comb begin
        found = |req;
        idx   = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = AW'(i);
        end
    end

endmodule

// File: rtl/res_st_ctrl.sv
// res_st_ctrl: reservation-station control. Tracks per-entry valid and
// operand-ready state, allocates the lowest free entry, wakes operands from
// the CDB and selects one ready entry to issue.
// Ports:
//   clk, rst                     - clock, async active-low reset
//   alloc_valid/alloc_ready      - dispatch handshake
//   alloc_rs{1,2}_rdy/_tag       - operand state of the dispatched op
//   st_wr_en/st_wr_addr          - payload storage write strobe/index
//   cdb_valid/cdb_tag            - result broadcast
//   issue_valid/ready/addr       - issue handshake and entry index
//   flush                        - drop all entries
//   occupancy                    - number of valid entries
// Build option: define QU_RES_ST_AGE_SEL_EN to issue the oldest ready entry
// (age matrix); otherwise the lowest-index ready entry issues.
module res_st_ctrl
    import qu_common::*;
#(
    parameter  int RES_ST_DEPTH = QU_RES_ST_DEPTH,
    parameter  int TAG_W        = QU_TAG_W,
    localparam int AW           = $clog2(RES_ST_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic             alloc_rs1_rdy,
    input  logic             alloc_rs2_rdy,
    input  logic [TAG_W-1:0] alloc_rs1_tag,
    input  logic [TAG_W-1:0] alloc_rs2_tag,
    output logic             st_wr_en,
    output logic [AW-1:0]    st_wr_addr,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [AW-1:0]    issue_addr,
    input  logic             flush,
    output logic [AW:0]      occupancy
);

    localparam logic [AW:0] FULL = (AW + 1)'(RES_ST_DEPTH);

    res_st_ctrl_t [RES_ST_DEPTH-1:0]             ent;
    logic         [RES_ST_DEPTH-1:0][TAG_W-1:0]  tag1;
    logic         [RES_ST_DEPTH-1:0][TAG_W-1:0]  tag2;

    logic [RES_ST_DEPTH-1:0] free_vec;
    logic [RES_ST_DEPTH-1:0] rdy_vec;
    logic [RES_ST_DEPTH-1:0] sel_vec;
    logic                    free_found;
    logic                    sel_found;
    logic [AW-1:0]           free_idx;
    logic [AW-1:0]           sel_idx;
    logic                    alloc_fire;
    logic                    issue_fire;
    logic                    alloc_rdy1;
    logic                    alloc_rdy2;

    always_comb begin
        for (int i = 0; i < RES_ST_DEPTH; i++) begin
            free_vec[i] = ~ent[i].valid;
            rdy_vec[i]  = ent[i].valid & ent[i].rdy1 & ent[i].rdy2;
        end
    end

    prio_enc #(.N(RES_ST_DEPTH)) u_free (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

`ifdef QU_RES_ST_AGE_SEL_EN
    // older[i][j] = entry i was allocated before entry j.
    logic [RES_ST_DEPTH-1:0][RES_ST_DEPTH-1:0] older;

    // Keep only the ready entry that no other ready entry predates; the
    // result is one-hot, so the encoder just converts it to an index.
    always_comb begin
        sel_vec = rdy_vec;
        for (int i = 0; i < RES_ST_DEPTH; i++) begin
            for (int j = 0; j < RES_ST_DEPTH; j++) begin
                if (rdy_vec[j] && older[j][i]) sel_vec[i] = 1'b0;
            end
        end
    end

    // A new entry is younger than everything: clear its row, set its column.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            older <= '0;
        end else if (flush) begin
            older <= '0;
        end else if (alloc_fire) begin
            for (int j = 0; j < RES_ST_DEPTH; j++) begin
                older[free_idx][j] <= 1'b0;
                if (AW'(j) != free_idx) older[j][free_idx] <= 1'b1;
            end
        end
    end
`else
    assign sel_vec = rdy_vec;
`endif

    prio_enc #(.N(RES_ST_DEPTH)) u_sel (
        .req   (sel_vec),
        .found (sel_found),
        .idx   (sel_idx)
    );

    assign alloc_ready = rst && !flush && (occupancy < FULL) && free_found;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign st_wr_en    = alloc_fire;
    assign st_wr_addr  = alloc_fire ? free_idx : '0;

    // Issue looks at registered state only; a same-cycle CDB hit shows up
    // one cycle later.
    assign issue_valid = sel_found && !flush;
    assign issue_addr  = issue_valid ? sel_idx : '0;
    assign issue_fire  = issue_valid && issue_ready;

    // Same-cycle wakeup bypass for the operands being dispatched.
    assign alloc_rdy1 = alloc_rs1_rdy || (cdb_valid && (cdb_tag == alloc_rs1_tag));
    assign alloc_rdy2 = alloc_rs2_rdy || (cdb_valid && (cdb_tag == alloc_rs2_tag));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent       <= '0;
            tag1      <= '0;
            tag2      <= '0;
            occupancy <= '0;
        end else if (flush) begin
            ent       <= '0;
            occupancy <= '0;
        end else begin
            for (int i = 0; i < RES_ST_DEPTH; i++) begin
                if (ent[i].valid && cdb_valid) begin
                    if (!ent[i].rdy1 && (tag1[i] == cdb_tag)) ent[i].rdy1 <= 1'b1;
                    if (!ent[i].rdy2 && (tag2[i] == cdb_tag)) ent[i].rdy2 <= 1'b1;
                end
            end
            // free_idx comes from the pre-edge free vector, so it never
            // equals the entry being issued this cycle.
            if (issue_fire) ent[issue_addr].valid <= 1'b0;
            if (alloc_fire) begin
                ent[free_idx].valid <= 1'b1;
                ent[free_idx].rdy1  <= alloc_rdy1;
                ent[free_idx].rdy2  <= alloc_rdy2;
                tag1[free_idx]      <= alloc_rs1_tag;
                tag2[free_idx]      <= alloc_rs2_tag;
            end
            case ({alloc_fire, issue_fire})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_res_st_ctrl.sv
// Directed bench for res_st_ctrl (default 32 entries, 6-bit tags).
module tb_res_st_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_valid, alloc_ready, alloc_rs1_rdy, alloc_rs2_rdy;
    logic [5:0] alloc_rs1_tag, alloc_rs2_tag, cdb_tag;
    logic       st_wr_en, cdb_valid, issue_valid, issue_ready, flush;
    logic [4:0] st_wr_addr, issue_addr;
    logic [5:0] occupancy;

    int checks   = 0;
    int failures = 0;

    res_st_ctrl dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_rs1_rdy(alloc_rs1_rdy), .alloc_rs2_rdy(alloc_rs2_rdy),
        .alloc_rs1_tag(alloc_rs1_tag), .alloc_rs2_tag(alloc_rs2_tag),
        .st_wr_en(st_wr_en), .st_wr_addr(st_wr_addr),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_addr(issue_addr),
        .flush(flush), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are read 1 unit
    // after that, well clear of either clock edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_rs1_rdy = 0; alloc_rs2_rdy = 0;
        alloc_rs1_tag = '0; alloc_rs2_tag = '0;
        cdb_valid = 0; cdb_tag = '0; issue_ready = 0; flush = 0;
    endtask

    task automatic reset_dut();
        idle();
        rst = 0;
        tick();
        rst = 1;
        tick();
    endtask

    task automatic alloc_one(input logic r1, input logic r2, input logic [5:0] t1, input logic [5:0] t2);
        alloc_valid = 1; alloc_rs1_rdy = r1; alloc_rs2_rdy = r2;
        alloc_rs1_tag = t1; alloc_rs2_tag = t2;
        tick();
        alloc_valid = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        alloc_valid = 1;
        tick();
        tick();
        checks++; if (occupancy !== 6'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid got=%b exp=0", issue_valid); end
        checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL reset_alloc_ready got=%b exp=0", alloc_ready); end
        checks++; if (st_wr_en !== 1'b0) begin failures++; $display("FAIL reset_st_wr_en got=%b exp=0", st_wr_en); end
        alloc_valid = 0;
        rst = 1;
        #1;
        checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL post_reset_alloc_ready got=%b exp=1", alloc_ready); end
        tick();
    endtask

    task automatic test_basic_issue();
        reset_dut();
        alloc_valid = 1; alloc_rs1_rdy = 1; alloc_rs2_rdy = 1;
        #1;
        checks++; if (st_wr_en !== 1'b1) begin failures++; $display("FAIL basic_wr_en got=%b exp=1", st_wr_en); end
        checks++; if (st_wr_addr !== 5'd0) begin failures++; $display("FAIL basic_wr_addr got=%0d exp=0", st_wr_addr); end
        tick();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_addr !== 5'd0) begin failures++; $display("FAIL basic_issue got=%b/%0d exp=1/0", issue_valid, issue_addr); end
        checks++; if (occupancy !== 6'd1) begin failures++; $display("FAIL basic_occ got=%0d exp=1", occupancy); end
        issue_ready = 1;
        tick();
        issue_ready = 0;
        #1;
        checks++; if (occupancy !== 6'd0 || issue_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%0d/%b exp=0/0", occupancy, issue_valid); end
    endtask

    task automatic test_cdb_wakeup();
        reset_dut();
        alloc_one(0, 1, 6'd5, 6'd0);
        cdb_valid = 1; cdb_tag = 6'd6;          // unrelated tag, must not wake
        #1;
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL cdb_pending got=%b exp=0", issue_valid); end
        tick();
        cdb_tag = 6'd5;
        #1;
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL cdb_no_bypass got=%b exp=0", issue_valid); end
        tick();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_addr !== 5'd0) begin failures++; $display("FAIL cdb_wakeup got=%b/%0d exp=1/0", issue_valid, issue_addr); end
    endtask

    task automatic test_bypass();
        reset_dut();
        cdb_valid = 1; cdb_tag = 6'd9;
        alloc_one(0, 1, 6'd9, 6'd0);
        idle();
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_addr !== 5'd0) begin failures++; $display("FAIL bypass got=%b/%0d exp=1/0", issue_valid, issue_addr); end
    endtask

    task automatic test_fill();
        int bad = 0;
        reset_dut();
        for (int i = 0; i < 32; i++) begin
            alloc_valid = 1; alloc_rs1_rdy = 0; alloc_rs2_rdy = 1;
            alloc_rs1_tag = 6'(i);
            #1;
            if (st_wr_addr !== 5'(i) || st_wr_en !== 1'b1) bad++;
            tick();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL fill_addrs got=%0d_wrong exp=0_wrong", bad); end
        idle();
        alloc_valid = 1;
        #1;
        checks++; if (alloc_ready !== 1'b0 || st_wr_en !== 1'b0) begin failures++; $display("FAIL full_ready got=%b/%b exp=0/0", alloc_ready, st_wr_en); end
        checks++; if (occupancy !== 6'd32) begin failures++; $display("FAIL full_occ got=%0d exp=32", occupancy); end
        alloc_valid = 0;
        cdb_valid = 1; cdb_tag = 6'd7;
        tick();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_addr !== 5'd7) begin failures++; $display("FAIL full_wake got=%b/%0d exp=1/7", issue_valid, issue_addr); end
        issue_ready = 1;
        tick();
        issue_ready = 0;
        #1;
        checks++; if (alloc_ready !== 1'b1 || occupancy !== 6'd31) begin failures++; $display("FAIL full_free got=%b/%0d exp=1/31", alloc_ready, occupancy); end
        alloc_valid = 1; alloc_rs1_tag = 6'd50;
        #1;
        checks++; if (st_wr_addr !== 5'd7) begin failures++; $display("FAIL refill_addr got=%0d exp=7", st_wr_addr); end
        tick();
        idle();
        #1;
        checks++; if (occupancy !== 6'd32) begin failures++; $display("FAIL refill_occ got=%0d exp=32", occupancy); end
    endtask

    task automatic test_alloc_issue_same();
        reset_dut();
        alloc_one(1, 1, 6'd0, 6'd0);
        alloc_one(0, 1, 6'd20, 6'd0);
        alloc_one(0, 1, 6'd20, 6'd0);
        alloc_one(1, 0, 6'd0, 6'd20);
        idle();
        #1;
        checks++; if (occupancy !== 6'd4 || issue_addr !== 5'd0) begin failures++; $display("FAIL ai_setup got=%0d/%0d exp=4/0", occupancy, issue_addr); end
        alloc_valid = 1; alloc_rs1_tag = 6'd20; alloc_rs2_rdy = 1;
        issue_ready = 1;
        #1;
        checks++; if (st_wr_en !== 1'b1 || st_wr_addr !== 5'd4) begin failures++; $display("FAIL ai_wr_addr got=%b/%0d exp=1/4", st_wr_en, st_wr_addr); end
        tick();
        idle();
        #1;
        checks++; if (occupancy !== 6'd4 || issue_valid !== 1'b0) begin failures++; $display("FAIL ai_occ got=%0d/%b exp=4/0", occupancy, issue_valid); end
        cdb_valid = 1; cdb_tag = 6'd20;
        tick();
        idle();
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_addr !== 5'd1) begin failures++; $display("FAIL ai_wake got=%b/%0d exp=1/1", issue_valid, issue_addr); end
    endtask

    task automatic test_flush();
        reset_dut();
        for (int i = 0; i < 10; i++) alloc_one(1, 1, 6'd0, 6'd0);
        idle();
        #1;
        checks++; if (occupancy !== 6'd10) begin failures++; $display("FAIL flush_setup got=%0d exp=10", occupancy); end
        flush = 1; alloc_valid = 1; alloc_rs1_rdy = 1; alloc_rs2_rdy = 1; issue_ready = 1;
        #1;
        checks++; if (alloc_ready !== 1'b0 || issue_valid !== 1'b0 || st_wr_en !== 1'b0) begin failures++; $display("FAIL flush_comb got=%b/%b/%b exp=0/0/0", alloc_ready, issue_valid, st_wr_en); end
        tick();
        idle();
        #1;
        checks++; if (occupancy !== 6'd0 || issue_valid !== 1'b0 || alloc_ready !== 1'b1) begin failures++; $display("FAIL flush_after got=%0d/%b/%b exp=0/0/1", occupancy, issue_valid, alloc_ready); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int i = 0; i < 3; i++) alloc_one(1, 1, 6'd0, 6'd0);
        idle();
        rst = 0;
        #1;
        checks++; if (occupancy !== 6'd0 || issue_valid !== 1'b0 || alloc_ready !== 1'b0) begin failures++; $display("FAIL reset_mid got=%0d/%b/%b exp=0/0/0", occupancy, issue_valid, alloc_ready); end
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_age_select();
        logic [4:0] exp_addr;
        reset_dut();
        alloc_one(0, 1, 6'd40, 6'd0);
        alloc_one(0, 1, 6'd41, 6'd0);
        alloc_one(0, 1, 6'd40, 6'd0);
        alloc_one(1, 1, 6'd0, 6'd0);
        idle();
        cdb_valid = 1; cdb_tag = 6'd41;
        tick();
        idle();
        #1;
        checks++; if (issue_addr !== 5'd1) begin failures++; $display("FAIL age_first got=%0d exp=1", issue_addr); end
        issue_ready = 1;
        tick();
        idle();
        alloc_one(1, 1, 6'd0, 6'd0);
        idle();
        #1;
`ifdef QU_RES_ST_AGE_SEL_EN
        exp_addr = 5'd3;
`else
        exp_addr = 5'd1;
`endif
        checks++; if (issue_valid !== 1'b1 || issue_addr !== exp_addr) begin failures++; $display("FAIL age_select got=%b/%0d exp=1/%0d", issue_valid, issue_addr, exp_addr); end
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_cdb_wakeup();
        test_bypass();
        test_fill();
        test_alloc_issue_same();
        test_flush();
        test_reset_mid();
        test_age_select();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
